// File: rtl/bsnn_pkg.sv
// Shared definitions for the spiking-network classification blocks:
// FSM state encoding and default geometry of the time-to-digital vectors.
package bsnn_pkg;

    localparam int DEF_TTD_WIDTH = 5;
    localparam int DEF_N_NEURONS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } ttd_state_e;

endpackage

// File: rtl/ttd_classifier_if.sv
// Bundle of the classifier's upstream (finish/vectors) and downstream
// (result handshake and status) signals.
interface ttd_classifier_if
    import bsnn_pkg::*;
#(
    parameter int TTD_WIDTH = DEF_TTD_WIDTH,
    parameter int N_NEURONS = DEF_N_NEURONS,
    localparam int IDX_WIDTH = ($clog2(N_NEURONS) < 1) ? 1 : $clog2(N_NEURONS)
);

    logic                           ttd_finish;
    logic [N_NEURONS*TTD_WIDTH-1:0] ttd_vectors;
    logic                           result_valid;
    logic                           result_ready;
    logic [IDX_WIDTH-1:0]           class_idx;
    logic [TTD_WIDTH-1:0]           class_time;
    logic                           no_spike;
    logic                           busy;
    logic                           overrun;

    // Upstream/consumer side: supplies vectors and finish, accepts results.
    modport master (
        output ttd_finish, ttd_vectors, result_ready,
        input  result_valid, class_idx, class_time, no_spike, busy, overrun
    );

    // Classifier side.
    modport slave (
        input  ttd_finish, ttd_vectors, result_ready,
        output result_valid, class_idx, class_time, no_spike, busy, overrun
    );

endinterface

// File: rtl/ttd_classifier.sv
// Winner-take-all classifier: on a rising edge of ttd_finish, snapshots the
// spike-time vector, scans one neuron per cycle for the earliest nonzero
// time (lowest index wins ties) and presents the result on a valid/ready
// handshake.
module ttd_classifier
    import bsnn_pkg::*;
#(
    parameter int TTD_WIDTH = DEF_TTD_WIDTH,
    parameter int N_NEURONS = DEF_N_NEURONS,
    localparam int IDX_WIDTH = ($clog2(N_NEURONS) < 1) ? 1 : $clog2(N_NEURONS)
) (
    input  logic                           CLK,
    input  logic                           RES,
    input  logic                           ttd_finish,
    input  logic [N_NEURONS*TTD_WIDTH-1:0] ttd_vectors,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [IDX_WIDTH-1:0]           class_idx,
    output logic [TTD_WIDTH-1:0]           class_time,
    output logic                           no_spike,
    output logic                           busy,
    output logic                           overrun
);

    // Scan counter runs 0..N_NEURONS; the terminal value marks "all examined".
    localparam int CNT_W = $clog2(N_NEURONS + 1);

    ttd_state_e                     state_q, state_d;
    logic                           finish_q, finish_d;
    logic [N_NEURONS*TTD_WIDTH-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]               scan_cnt_q, scan_cnt_d;
    logic [TTD_WIDTH-1:0]           best_time_q, best_time_d;
    logic [IDX_WIDTH-1:0]           best_idx_q, best_idx_d;
    logic                           found_q, found_d;
    logic                           valid_q, valid_d;
    logic [IDX_WIDTH-1:0]           class_idx_q, class_idx_d;
    logic [TTD_WIDTH-1:0]           class_time_q, class_time_d;
    logic                           no_spike_q, no_spike_d;
    logic                           busy_q, busy_d;
    logic                           overrun_q, overrun_d;

    logic                           trigger;
    logic [TTD_WIDTH-1:0]           cur_time;
    logic [IDX_WIDTH-1:0]           cur_idx;

    // Select the snapshot entry addressed by the scan counter.
    always_comb begin
        cur_time = '0;
        cur_idx  = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            if (scan_cnt_q == CNT_W'(i)) begin
                cur_time = snap_q[i*TTD_WIDTH +: TTD_WIDTH];
                cur_idx  = IDX_WIDTH'(i);
            end
        end
    end

    // Next-state logic: edge detect, snapshot, running minimum, handshake.
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        scan_cnt_d   = scan_cnt_q;
        best_time_d  = best_time_q;
        best_idx_d   = best_idx_q;
        found_d      = found_q;
        valid_d      = valid_q;
        class_idx_d  = class_idx_q;
        class_time_d = class_time_q;
        no_spike_d   = no_spike_q;
        overrun_d    = overrun_q;

        finish_d = ttd_finish;
        trigger  = ttd_finish & ~finish_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    snap_d      = ttd_vectors;
                    scan_cnt_d  = '0;
                    best_time_d = '0;
                    best_idx_d  = '0;
                    found_d     = 1'b0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (scan_cnt_q == CNT_W'(N_NEURONS)) begin
                    valid_d      = 1'b1;
                    class_idx_d  = best_idx_q;
                    class_time_d = best_time_q;
                    no_spike_d   = ~found_q;
                    state_d      = DONE;
                end else begin
                    if ((cur_time != '0) && (!found_q || (cur_time < best_time_q))) begin
                        best_time_d = cur_time;
                        best_idx_d  = cur_idx;
                        found_d     = 1'b1;
                    end
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (valid_q && result_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A trigger outside IDLE (including the handshake edge) is lost.
        if (trigger && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q      <= IDLE;
            finish_q     <= 1'b1;
            snap_q       <= '0;
            scan_cnt_q   <= '0;
            best_time_q  <= '0;
            best_idx_q   <= '0;
            found_q      <= 1'b0;
            valid_q      <= 1'b0;
            class_idx_q  <= '0;
            class_time_q <= '0;
            no_spike_q   <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            finish_q     <= finish_d;
            snap_q       <= snap_d;
            scan_cnt_q   <= scan_cnt_d;
            best_time_q  <= best_time_d;
            best_idx_q   <= best_idx_d;
            found_q      <= found_d;
            valid_q      <= valid_d;
            class_idx_q  <= class_idx_d;
            class_time_q <= class_time_d;
            no_spike_q   <= no_spike_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign result_valid = valid_q;
    assign class_idx    = class_idx_q;
    assign class_time   = class_time_q;
    assign no_spike     = no_spike_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_ttd_classifier.sv
// Scoreboard bench for ttd_classifier: stimulus pushes the expected result,
// a negedge monitor pops and compares on every accepted result.
module tb_ttd_classifier;
    import bsnn_pkg::*;

    localparam int W  = 5;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  tm;
        logic          ns;
    } res_t;

    logic CLK = 1'b0;
    logic RES = 1'b1;

    ttd_classifier_if #(.TTD_WIDTH(W), .N_NEURONS(N)) bus ();

    ttd_classifier #(.TTD_WIDTH(W), .N_NEURONS(N)) dut (
        .CLK          (CLK),
        .RES          (RES),
        .ttd_finish   (bus.ttd_finish),
        .ttd_vectors  (bus.ttd_vectors),
        .result_valid (bus.result_valid),
        .result_ready (bus.result_ready),
        .class_idx    (bus.class_idx),
        .class_time   (bus.class_time),
        .no_spike     (bus.no_spike),
        .busy         (bus.busy),
        .overrun      (bus.overrun)
    );

    always #5 CLK = ~CLK;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input int a, input int b, input int c, input int d);
        logic [N*W-1:0] v;
        v = '0;
        v[0*W +: W] = W'(a);
        v[1*W +: W] = W'(b);
        v[2*W +: W] = W'(c);
        v[3*W +: W] = W'(d);
        return v;
    endfunction

    function automatic res_t mk(input int i, input int t, input bit ns);
        res_t r;
        r.idx = IW'(i);
        r.tm  = W'(t);
        r.ns  = ns;
        return r;
    endfunction

    // Monitor: every accepted result is checked against the scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RES && bus.result_valid && bus.result_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("class_idx",  int'(bus.class_idx),  int'(e.idx));
                    chk("class_time", int'(bus.class_time), int'(e.tm));
                    chk("no_spike",   int'(bus.no_spike),   int'(e.ns));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},    int'(bus.result_valid), 0);
        chk({tag, "_idx"},      int'(bus.class_idx),    0);
        chk({tag, "_time"},     int'(bus.class_time),   0);
        chk({tag, "_no_spike"}, int'(bus.no_spike),     0);
        chk({tag, "_busy"},     int'(bus.busy),         0);
        chk({tag, "_overrun"},  int'(bus.overrun),      0);
    endtask

    task automatic no_valid_for(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge CLK); #1;
            if (bus.result_valid) seen++;
        end
        chk({tag, "_no_result"}, seen, 0);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!bus.result_valid && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, "_valid_seen"}, int'(bus.result_valid), 1);
    endtask

    // One inference with ready held high; optional scrambling of the vectors
    // after the trigger edge.
    task automatic classify(input string tag, input logic [N*W-1:0] v, input res_t e,
                            input bit scramble);
        int n;
        @(posedge CLK); #1;
        bus.ttd_vectors = v;
        bus.ttd_finish  = 1'b1;
        exp_q.push_back(e);
        @(posedge CLK); #1;
        chk({tag, "_busy"}, int'(bus.busy), 1);
        n = 0;
        while (!bus.result_valid && n < 20) begin
            if (scramble) bus.ttd_vectors = (N*W)'($urandom);
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, "_latency"}, n, N + 1);
        n = 0;
        while (bus.result_valid && n < 20) begin
            if (scramble) bus.ttd_vectors = (N*W)'($urandom);
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, "_accepted"}, int'(bus.result_valid), 0);
        chk({tag, "_idle"},     int'(bus.busy),         0);
        bus.ttd_finish = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        res_t held;

        bus.ttd_finish   = 1'b1;
        bus.ttd_vectors  = '0;
        bus.result_ready = 1'b1;
        RES = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RES = 1'b0;
        check_all_zero("reset");
        // finish still high after reset must not start an inference
        repeat (3) @(posedge CLK);
        #1;
        chk("no_spurious_busy", int'(bus.busy), 0);
        bus.ttd_finish = 1'b0;

        classify("basic",  pack(7, 3, 9, 5), mk(1, 3, 0), 1'b0);
        classify("zero",   pack(4, 0, 4, 2), mk(3, 2, 0), 1'b0);
        classify("tie",    pack(4, 6, 4, 6), mk(0, 4, 0), 1'b0);
        classify("nospk",  pack(0, 0, 0, 0), mk(0, 0, 1), 1'b0);
        classify("last",   pack(0, 0, 0, 1), mk(3, 1, 0), 1'b0);
        classify("maxtie", pack(31, 31, 0, 31), mk(0, 31, 0), 1'b0);
        classify("snap",   pack(8, 2, 9, 6), mk(1, 2, 0), 1'b1);

        // Backpressure with a lost second finish edge.
        bus.result_ready = 1'b0;
        @(posedge CLK); #1;
        bus.ttd_vectors = pack(5, 9, 2, 7);
        bus.ttd_finish  = 1'b1;
        exp_q.push_back(mk(2, 2, 0));
        wait_valid("hold", n);
        held = {bus.class_idx, bus.class_time, bus.no_spike};
        bus.ttd_finish = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) bus.ttd_finish = 1'b1;
            if (i == 4) bus.ttd_vectors = pack(1, 1, 1, 1);
            @(posedge CLK); #1;
            chk("hold_valid", int'(bus.result_valid), 1);
            chk("hold_outputs", int'({bus.class_idx, bus.class_time, bus.no_spike}), int'(held));
        end
        chk("hold_overrun", int'(bus.overrun), 1);
        bus.result_ready = 1'b1;
        @(posedge CLK); #1;
        chk("hold_released", int'(bus.result_valid), 0);
        no_valid_for("hold", 10);
        chk("overrun_sticky", int'(bus.overrun), 1);
        bus.ttd_finish = 1'b0;

        // Reset two cycles into SCAN aborts the inference.
        @(posedge CLK); #1;
        bus.ttd_vectors = pack(3, 3, 3, 3);
        bus.ttd_finish  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("abort_in_scan", int'(bus.busy), 1);
        RES = 1'b1;
        @(posedge CLK); #1;
        RES = 1'b0;
        check_all_zero("abort");
        no_valid_for("abort", 10);
        bus.ttd_finish = 1'b0;
        classify("after_abort", pack(6, 5, 0, 9), mk(1, 5, 0), 1'b0);

        // Trigger coinciding with the DONE handshake is dropped.
        bus.result_ready = 1'b0;
        @(posedge CLK); #1;
        bus.ttd_vectors = pack(2, 7, 1, 8);
        bus.ttd_finish  = 1'b1;
        exp_q.push_back(mk(2, 1, 0));
        wait_valid("hs_edge", n);
        bus.ttd_finish = 1'b0;
        @(posedge CLK); #1;
        chk("hs_edge_no_overrun_yet", int'(bus.overrun), 0);
        bus.ttd_finish   = 1'b1;
        bus.result_ready = 1'b1;
        @(posedge CLK); #1;
        chk("hs_edge_overrun", int'(bus.overrun),      1);
        chk("hs_edge_idle",    int'(bus.busy),         0);
        chk("hs_edge_valid",   int'(bus.result_valid), 0);
        no_valid_for("hs_edge", 10);
        bus.ttd_finish = 1'b0;

        repeat (2) @(posedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
